macguffin_arbiter: RTL and testbench
====================================

// Module: macguffin_arbiter
// PURPOSE
//  Shares one MacGuffin encryption core between N_REQ AXI-Stream requesters.
//  - Round-robin arbitration of 64-bit plaintext blocks into the core.
//  - Records the requester index of every accepted block in an in-order tag FIFO.
//  - Routes each ciphertext back to the requester that issued it.
//  - Sits between the client ports and the encryption/key-setup pair.
//  - Issues nothing to the core until the key schedule reports ready.
// PARAMETERS
//  N_REQ      4   number of requesters, 2..8
//  TAG_DEPTH  8   max blocks in flight inside the core (power of 2, >=2)
// PORTS
//  clk            in   1         clock, all logic on rising edge
//  rst            in   1         asynchronous, active-high reset
//  key_ready      in   1         round keys valid; gates new grants
//  s_req_tdata    in   N_REQ*64  plaintext, requester i at [64*i +: 64]
//  s_req_tvalid   in   N_REQ     per-requester valid
//  s_req_tready   out  N_REQ     per-requester ready (one-hot or zero)
//  m_rsp_tdata    out  64        ciphertext, shared by all requesters
//  m_rsp_tvalid   out  N_REQ     per-requester valid (one-hot or zero)
//  m_rsp_tready   in   N_REQ     per-requester ready
//  core_tdata     out  64        plaintext to core
//  core_tvalid    out  1         valid to core
//  core_tready    in   1         core ready
//  core_rsp_tdata in   64        ciphertext from core
//  core_rsp_tvalid in  1         core output valid
//  core_rsp_tready out 1         ready to core output
//  err_orphan     out  1         sticky: core produced output with empty tag FIFO
// BEHAVIOUR
//  Reset values
//  - FSM = IDLE, rr_ptr = 0, tag FIFO empty.
//  - All tready/tvalid outputs 0; err_orphan 0; core_tdata 0.
//  Request FSM
//  - IDLE -> SEND when key_ready, tag FIFO not full and any s_req_tvalid is high.
//    - Winner = first valid index searched from rr_ptr upward, wrapping at N_REQ.
//    - Winner index and data are registered on the IDLE->SEND edge.
//  - SEND: core_tvalid = 1, holding the registered data.
//    - On core_tvalid & core_tready: push winner index to the tag FIFO.
//    - In the same cycle assert s_req_tready[winner] for exactly that cycle.
//    - rr_ptr <= winner+1 mod N_REQ; FSM -> IDLE.
//  - Latency: requester valid to core_tvalid = 1 cycle. Minimum 2 cycles per block per grant.
//  - In SEND, key_ready falling does not abort; the block completes.
//  - Requesters must hold tvalid and tdata until their tready, per AXI rules.
//  Response path (combinational, no added latency)
//  - m_rsp_tdata = core_rsp_tdata.
//  - m_rsp_tvalid[head] = core_rsp_tvalid & !fifo_empty; all other bits 0.
//  - core_rsp_tready = m_rsp_tready[head] & !fifo_empty.
//  - Pop on core_rsp_tvalid & core_rsp_tready.
//  - Backpressure from one requester stalls all returns, in order by design.
//  Boundaries
//  - FIFO full: no IDLE->SEND transition. A push and pop in the same cycle while full is legal.
//  - Simultaneous push and pop at any level: count unchanged, both pointers advance and wrap mod TAG_DEPTH.
//  - core_rsp_tvalid with empty FIFO:
//    - core_rsp_tready = 0 and err_orphan <= 1, held until reset.
//    - No m_rsp_tvalid is asserted.
//  - Only one requester valid: it wins regardless of rr_ptr.
//  - Reset mid-operation: in-flight tags are discarded and the FSM returns to IDLE. Software re-keys and resubmits.
// STRUCTURE
//  - macguffin_pkg: BLOCK_W=64, typedef logic [63:0] block_t, and the req_idx_t width function.
//  - Sub-module macguffin_tag_fifo: synchronous FIFO.
//    - Params WIDTH, DEPTH; ports push/pop/full/empty/head.
//    - Asynchronous active-high reset.
//  - The arbiter holds the FSM, the round-robin search and the response demux.
// TESTING
//  1. key_ready=0, all valids high for 20 cycles
//     -> core_tvalid stays 0 and s_req_tready stays 0.
//  2. N_REQ=4, all valid, core always ready, echo core with 3-cycle latency
//     -> grant order 0,1,2,3,0; each m_rsp_tvalid bit matches its issuer's data.
//  3. Core returns 8 blocks late, TAG_DEPTH=8
//     -> 9th request is not granted until the first response pop. The 9th grant follows in the next cycle.
//  4. m_rsp_tready[1]=0 while head=1
//     -> core_rsp_tready=0; requester 2's result waits. Release -> both delivered in order 1,2.
//  5. core_rsp_tvalid pulse with FIFO empty
//     -> err_orphan=1 persists until rst; no m_rsp_tvalid bit asserted.
//  6. rst asserted while in SEND with 3 tags outstanding
//     -> all outputs 0 asynchronously; after release the FIFO is empty and rr_ptr=0.

Source files
------------

// File: rtl/macguffin_pkg.sv
// Shared types and helpers for the MacGuffin arbiter slice.
package macguffin_pkg;

    localparam int unsigned BLOCK_W = 64;

    typedef logic [BLOCK_W-1:0] block_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned req_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/macguffin_tag_fifo.sv
// In-order FIFO of requester tags for blocks in flight inside the core.
module macguffin_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_en, pop_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign pop_en  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign push_en = push_i & (~full_o | pop_en);

    // Occupancy next-state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count state; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Tag storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/macguffin_arbiter.sv
// Round-robin sharing of one MacGuffin core between N_REQ stream requesters,
// with in-order routing of ciphertext back to the issuing requester.
module macguffin_arbiter
    import macguffin_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_ready,
    input  logic [N_REQ*BLOCK_W-1:0] s_req_tdata,
    input  logic [N_REQ-1:0]         s_req_tvalid,
    output logic [N_REQ-1:0]         s_req_tready,
    output logic [BLOCK_W-1:0]       m_rsp_tdata,
    output logic [N_REQ-1:0]         m_rsp_tvalid,
    input  logic [N_REQ-1:0]         m_rsp_tready,
    output logic [BLOCK_W-1:0]       core_tdata,
    output logic                     core_tvalid,
    input  logic                     core_tready,
    input  logic [BLOCK_W-1:0]       core_rsp_tdata,
    input  logic                     core_rsp_tvalid,
    output logic                     core_rsp_tready,
    output logic                     err_orphan
);
    localparam int unsigned IdxW = req_idx_w(N_REQ);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e          state_q;
    logic [IdxW-1:0] win_q, rr_q, rr_next, pick, head;
    block_t          data_q;
    block_t          req_data [N_REQ];
    logic            any_valid, fifo_full, fifo_empty, push, pop, err_q;
    int unsigned     cand;

    // Unpack the flat request bus into per-requester blocks.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_data[i] = s_req_tdata[BLOCK_W*i +: BLOCK_W];
        end
    end

    // Round-robin search: walk offsets downward so the nearest valid from rr_q wins last.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        cand      = 0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            cand = (32'(rr_q) + k - 1) % N_REQ;
            if (s_req_tvalid[IdxW'(cand)]) begin
                any_valid = 1'b1;
                pick      = IdxW'(cand);
            end
        end
    end

    assign rr_next = (32'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;

    // Request FSM: latch winner and its block, then hold it to the core until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            win_q   <= '0;
            rr_q    <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (key_ready && !fifo_full && any_valid) begin
                        state_q <= StSend;
                        win_q   <= pick;
                        data_q  <= req_data[pick];
                    end
                end
                StSend: begin
                    // key_ready is not consulted here: a started block always completes.
                    if (core_tready) begin
                        state_q <= StIdle;
                        rr_q    <= rr_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_tvalid = (state_q == StSend);
    assign core_tdata  = data_q;
    assign push        = core_tvalid & core_tready;

    // Requester handshake completes in the same cycle the core accepts its block.
    always_comb begin
        s_req_tready = '0;
        if (push) s_req_tready[win_q] = 1'b1;
    end

    macguffin_tag_fifo #(
        .WIDTH (IdxW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (win_q),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign m_rsp_tdata     = core_rsp_tdata;
    assign core_rsp_tready = ~fifo_empty & m_rsp_tready[head];
    assign pop             = core_rsp_tvalid & core_rsp_tready;

    // Steer response valid to the requester at the head of the tag FIFO.
    always_comb begin
        m_rsp_tvalid = '0;
        if (!fifo_empty) m_rsp_tvalid[head] = core_rsp_tvalid;
    end

    // Sticky flag for core output that no outstanding tag can account for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (core_rsp_tvalid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_orphan = err_q;

endmodule

// File: tb/tb_macguffin_arbiter.sv
// Self-checking bench for macguffin_arbiter: requester and core models plus a response scoreboard.
module tb_macguffin_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned D = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           key_ready = 1'b0;
    logic [N*64-1:0] s_req_tdata;
    logic [N-1:0]   s_req_tvalid, s_req_tready;
    logic [63:0]    m_rsp_tdata;
    logic [N-1:0]   m_rsp_tvalid;
    logic [N-1:0]   m_rsp_tready;
    logic [63:0]    core_tdata;
    logic           core_tvalid;
    logic           core_tready;
    logic [63:0]    core_rsp_tdata;
    logic           core_rsp_tvalid;
    logic           core_rsp_tready;
    logic           err_orphan;

    macguffin_arbiter #(
        .N_REQ     (N),
        .TAG_DEPTH (D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .key_ready       (key_ready),
        .s_req_tdata     (s_req_tdata),
        .s_req_tvalid    (s_req_tvalid),
        .s_req_tready    (s_req_tready),
        .m_rsp_tdata     (m_rsp_tdata),
        .m_rsp_tvalid    (m_rsp_tvalid),
        .m_rsp_tready    (m_rsp_tready),
        .core_tdata      (core_tdata),
        .core_tvalid     (core_tvalid),
        .core_tready     (core_tready),
        .core_rsp_tdata  (core_rsp_tdata),
        .core_rsp_tvalid (core_rsp_tvalid),
        .core_rsp_tready (core_rsp_tready),
        .err_orphan      (err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; logic [63:0] d; } exp_t;
    typedef struct { logic [63:0] d; int due; } core_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] req_data [N];
    int          seq [N];
    logic [N-1:0] req_en = '0;
    int          grant_limit = 0;
    int          n_grants = 0;
    int          n_rsps = 0;
    int          grant_log[$];
    int          rsp_log[$];
    exp_t        sb[$];
    core_t       core_q[$];
    int          core_lat = 3;
    bit          core_hold = 1'b0;
    bit          core_rdy = 1'b1;
    bit          force_orphan = 1'b0;
    bit          core_popped = 1'b0;
    logic        obs_core_tvalid, obs_core_rsp_tready;
    logic [N-1:0] obs_s_req_tready, obs_m_rsp_tvalid;

    function automatic logic [63:0] enc(input logic [63:0] x);
        return {x[31:0], x[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] mk_data(input int i, input int s);
        return {i[7:0], 24'hA5C3E1, s[31:0]};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            s_req_tdata[64*i +: 64] = req_data[i];
            s_req_tvalid[i] = req_en[i] && (n_grants < grant_limit);
        end
        core_tready = core_rdy;
        if (force_orphan) begin
            core_rsp_tvalid = 1'b1;
            core_rsp_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
        end else if (!core_hold && core_q.size() > 0 && core_q[0].due <= cyc) begin
            core_rsp_tvalid = 1'b1;
            core_rsp_tdata  = core_q[0].d;
        end else begin
            core_rsp_tvalid = 1'b0;
            core_rsp_tdata  = '0;
        end
    endtask

    // One clock: observe at negedge, update models and scoreboard, drive after posedge.
    task automatic cycle();
        @(negedge clk);
        obs_core_tvalid     = core_tvalid;
        obs_core_rsp_tready = core_rsp_tready;
        obs_s_req_tready    = s_req_tready;
        obs_m_rsp_tvalid    = m_rsp_tvalid;
        if (s_req_tready != '0) begin
            checks++;
            if (!$onehot(s_req_tready)) begin
                errors++;
                $display("FAIL req_tready_onehot: got %b want one-hot", s_req_tready);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (s_req_tvalid[i] && s_req_tready[i]) begin
                checks++;
                if (core_tdata !== req_data[i]) begin
                    errors++;
                    $display("FAIL grant_data req%0d: got %h want %h", i, core_tdata, req_data[i]);
                end
                sb.push_back('{i, enc(req_data[i])});
                grant_log.push_back(i);
                n_grants++;
                seq[i]++;
                req_data[i] = mk_data(i, seq[i]);
            end
        end
        if (core_rsp_tvalid && core_rsp_tready && core_q.size() > 0) begin
            void'(core_q.pop_front());
            core_popped = 1'b1;
        end
        if (core_tvalid && core_tready) core_q.push_back('{enc(core_tdata), cyc + core_lat});
        if (m_rsp_tvalid != '0) begin
            checks++;
            if (!$onehot(m_rsp_tvalid)) begin
                errors++;
                $display("FAIL rsp_valid_onehot: got %b want one-hot", m_rsp_tvalid);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_rsp_tvalid[i] && m_rsp_tready[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got req%0d data %h want none", i, m_rsp_tdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.idx != i || m_rsp_tdata !== e.d) begin
                        errors++;
                        $display("FAIL rsp_route: got req%0d %h want req%0d %h",
                                 i, m_rsp_tdata, e.idx, e.d);
                    end
                end
                rsp_log.push_back(i);
                n_rsps++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic wait_grants(input int target, input int budget, output bit ok);
        for (int k = 0; k < budget && n_grants < target; k++) cycle();
        ok = (n_grants >= target);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        for (int k = 0; k < budget && (sb.size() > 0 || core_q.size() > 0); k++) cycle();
        ok = (sb.size() == 0 && core_q.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_rsp_tready = '1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (core_tvalid !== 1'b0) begin errors++; $display("FAIL rst_core_tvalid: got %b want 0", core_tvalid); end
        checks++; if (s_req_tready !== '0) begin errors++; $display("FAIL rst_req_tready: got %b want 0", s_req_tready); end
        checks++; if (m_rsp_tvalid !== '0) begin errors++; $display("FAIL rst_rsp_tvalid: got %b want 0", m_rsp_tvalid); end
        checks++; if (core_rsp_tready !== 1'b0) begin errors++; $display("FAIL rst_core_rsp_tready: got %b want 0", core_rsp_tready); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rst_err_orphan: got %b want 0", err_orphan); end
        checks++; if (core_tdata !== '0) begin errors++; $display("FAIL rst_core_tdata: got %h want 0", core_tdata); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_key();
        int base;
        base = n_grants;
        key_ready = 1'b0;
        req_en = '1;
        grant_limit = 1000;
        drive_inputs();
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks++;
            if (obs_core_tvalid !== 1'b0 || obs_s_req_tready !== '0) begin
                errors++;
                $display("FAIL no_key cyc%0d: got tvalid %b tready %b want 0 0",
                         k, obs_core_tvalid, obs_s_req_tready);
            end
        end
        checks++;
        if (n_grants != base) begin errors++; $display("FAIL no_key_grants: got %0d want %0d", n_grants, base); end
        req_en = '0;
        drive_inputs();
    endtask

    task automatic test_rr_order();
        int base, rbase;
        bit ok;
        base = n_grants;
        rbase = n_rsps;
        key_ready = 1'b1;
        grant_limit = base + 5;
        req_en = '1;
        drive_inputs();
        wait_grants(base + 5, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d grants want %0d", n_grants - base, 5); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (grant_log[base+k] != k % N) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", k, grant_log[base+k], k % N);
            end
        end
        wait_drain(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_drain: got %0d pending want 0", sb.size()); end
        checks++; if (n_rsps - rbase != 5) begin errors++; $display("FAIL rr_rsp_count: got %0d want 5", n_rsps - rbase); end
        req_en = '0;
    endtask

    task automatic test_fifo_full();
        int base;
        bit ok;
        base = n_grants;
        core_hold = 1'b1;
        grant_limit = base + 9;
        req_en = '1;
        drive_inputs();
        repeat (40) cycle();
        checks++; if (n_grants != base + 8) begin errors++; $display("FAIL full_grants: got %0d want 8", n_grants - base); end
        checks++; if (obs_core_tvalid !== 1'b0) begin errors++; $display("FAIL full_tvalid: got %b want 0", obs_core_tvalid); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (grant_log[base+k] != (1 + k) % N) begin
                errors++;
                $display("FAIL full_order[%0d]: got %0d want %0d", k, grant_log[base+k], (1 + k) % N);
            end
        end
        core_hold = 1'b0;
        core_popped = 1'b0;
        drive_inputs();
        for (int k = 0; k < 20 && !core_popped; k++) cycle();
        checks++; if (!core_popped) begin errors++; $display("FAIL full_pop_timeout: got no pop want pop"); end
        checks++; if (core_tvalid !== 1'b0) begin errors++; $display("FAIL full_pop_edge_tvalid: got %b want 0", core_tvalid); end
        cycle();
        checks++; if (core_tvalid !== 1'b1) begin errors++; $display("FAIL full_next_grant: got %b want 1", core_tvalid); end
        wait_grants(base + 9, 20, ok);
        checks++; if (!ok || grant_log[base+8] != 1) begin errors++; $display("FAIL full_ninth: got %0d want 1", ok ? grant_log[base+8] : -1); end
        wait_drain(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_drain: got %0d pending want 0", sb.size()); end
        req_en = '0;
    endtask

    task automatic test_backpressure();
        int base, rbase;
        bit ok;
        base = n_grants;
        rbase = n_rsps;
        m_rsp_tready = 4'b1101;
        req_en = 4'b0010;
        grant_limit = base + 1;
        drive_inputs();
        wait_grants(base + 1, 20, ok);
        req_en = 4'b0100;
        grant_limit = base + 2;
        drive_inputs();
        wait_grants(base + 2, 20, ok);
        checks++; if (!ok || grant_log[base] != 1 || grant_log[base+1] != 2) begin errors++; $display("FAIL bp_grants: got ok %0d want 1,2", ok); end
        repeat (8) cycle();
        checks++; if (obs_core_rsp_tready !== 1'b0) begin errors++; $display("FAIL bp_core_rsp_tready: got %b want 0", obs_core_rsp_tready); end
        checks++; if (obs_m_rsp_tvalid !== 4'b0010) begin errors++; $display("FAIL bp_rsp_tvalid: got %b want 0010", obs_m_rsp_tvalid); end
        checks++; if (n_rsps != rbase) begin errors++; $display("FAIL bp_held: got %0d delivered want 0", n_rsps - rbase); end
        m_rsp_tready = '1;
        drive_inputs();
        wait_drain(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got %0d pending want 0", sb.size()); end
        checks++;
        if (n_rsps != rbase + 2 || rsp_log[rbase] != 1 || rsp_log[rbase+1] != 2) begin
            errors++;
            $display("FAIL bp_order: got %0d responses want req1 then req2", n_rsps - rbase);
        end
        req_en = '0;
    endtask

    task automatic test_orphan();
        force_orphan = 1'b1;
        drive_inputs();
        force_orphan = 1'b0;
        cycle();
        checks++; if (obs_m_rsp_tvalid !== '0) begin errors++; $display("FAIL orphan_rsp_tvalid: got %b want 0", obs_m_rsp_tvalid); end
        checks++; if (obs_core_rsp_tready !== 1'b0) begin errors++; $display("FAIL orphan_tready: got %b want 0", obs_core_rsp_tready); end
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
        repeat (5) cycle();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        base = n_grants;
        core_hold = 1'b1;
        req_en = '1;
        grant_limit = base + 100;
        drive_inputs();
        wait_grants(base + 3, 30, ok);
        core_rdy = 1'b0;
        drive_inputs();
        cycle();
        cycle();
        checks++; if (!ok || obs_core_tvalid !== 1'b1) begin errors++; $display("FAIL mid_send: got tvalid %b want 1", obs_core_tvalid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (core_tvalid !== 1'b0) begin errors++; $display("FAIL mid_core_tvalid: got %b want 0", core_tvalid); end
        checks++; if (s_req_tready !== '0) begin errors++; $display("FAIL mid_req_tready: got %b want 0", s_req_tready); end
        checks++; if (core_tdata !== '0) begin errors++; $display("FAIL mid_core_tdata: got %h want 0", core_tdata); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL mid_err_orphan: got %b want 0", err_orphan); end
        sb.delete();
        core_q.delete();
        core_hold = 1'b0;
        core_rdy = 1'b1;
        req_en = '0;
        drive_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        checks++; if (obs_core_rsp_tready !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty: got %b want 0", obs_core_rsp_tready); end
        base = n_grants;
        grant_limit = base + 1;
        req_en = '1;
        drive_inputs();
        wait_grants(base + 1, 20, ok);
        checks++; if (!ok || grant_log[base] != 0) begin errors++; $display("FAIL mid_rr_reset: got %0d want 0", ok ? grant_log[base] : -1); end
        wait_drain(50, ok);
        checks++; if (!ok || err_orphan !== 1'b0) begin errors++; $display("FAIL mid_after: got drained %0d err %b want 1 0", ok, err_orphan); end
        req_en = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            req_data[i] = mk_data(i, 0);
        end
        test_reset();
        test_no_key();
        test_rr_order();
        test_fifo_full();
        test_backpressure();
        test_orphan();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
